// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - register-file writeback queue with optional pending-write lookup (RF_WBQ_FWD_EN)
module rf_wb_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_stall,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          lk_addr,
    output logic                       lk_hit,
    output logic [DATA_W-1:0]          lk_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;

    // Handshake and head presentation; register 0 requests complete the handshake but are dropped
    always_comb begin
        in_ready = (count_q != CW'(DEPTH));
        wr_en    = (count_q != '0);
        push     = in_valid && in_ready && (in_addr != '0);
        pop      = wr_en && !wr_stall;
        wr_addr  = wr_en ? addr_q[rd_ptr_q] : '0;
        wr_data  = wr_en ? data_q[rd_ptr_q] : '0;
        count    = count_q;
    end

    // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = in_addr;
            data_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all pending entries
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied, so no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

`ifdef RF_WBQ_FWD_EN
    logic [PW-1:0] lk_idx;

    // Scan occupied entries oldest to newest so the newest match wins; incoming push is not visible
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[lk_idx] == lk_addr) && (lk_addr != '0)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end
`else
    logic lk_unused;

    // Lookup disabled: outputs tied off, address port kept for a stable interface
    always_comb begin
        lk_unused = ^lk_addr;
        lk_hit    = 1'b0;
        lk_data   = '0;
    end
`endif

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: register address width.
REQ-002 SHALL have parameter DATA_W, default 32: register data width.
REQ-003 SHALL have parameter DEPTH, default 4, power of two >= 2: number of queue entries.
REQ-004 SHALL have a single clock domain with synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  writeback request valid.
REQ-008 in_ready  out  1  queue can accept a request this cycle.
REQ-009 in_addr  in  ADDR_W  destination register of request.
REQ-010 in_data  in  DATA_W  data of request.
REQ-011 wr_en  out  1  register-file write strobe (head entry valid).
REQ-012 wr_addr  out  ADDR_W  register-file write address (head entry).
REQ-013 wr_data  out  DATA_W  register-file write data (head entry).
REQ-014 wr_stall  in  1  register-file write port busy; head is held.
REQ-015 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 lk_addr  in  ADDR_W  read address to check against pending writes.
REQ-017 lk_hit  out  1  pending write to lk_addr exists.
REQ-018 lk_data  out  DATA_W  data of the newest pending write to lk_addr.

Function
REQ-019 SHALL implement an in-order FIFO of DEPTH {addr,data} entries feeding the register-file write port.
REQ-020 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal (count != DEPTH), independent of wr_stall (no pass-through when full).
REQ-021 A request with in_addr == 0 SHALL be accepted (handshake completes) but not stored; count unchanged.
REQ-022 wr_en SHALL equal (count != 0); wr_addr/wr_data SHALL show the head entry, and SHALL be 0 when empty.
REQ-023 Pop SHALL occur when wr_en && !wr_stall; head advances on that edge.
REQ-024 Latency: a request accepted at edge t SHALL appear on wr_* in the cycle after t if the queue was empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, including when count == DEPTH-1 or count == 1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-027 While wr_stall is high, wr_en/wr_addr/wr_data SHALL remain stable.
REQ-028 Lookup SHALL be combinational over occupied entries only; a same-cycle incoming push SHALL NOT be visible.
REQ-029 When multiple occupied entries match lk_addr, lk_data SHALL be the most recently pushed one.
REQ-030 lk_addr == 0 SHALL never hit; on miss lk_hit = 0 and lk_data = 0.

Reset
REQ-031 On a clock edge with rst high, pointers and count SHALL clear to 0; the queue empties and pending entries are discarded, also mid-operation.
REQ-032 During and after reset: in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, count = 0, lk_hit = 0, lk_data = 0.
REQ-033 A push presented in the reset cycle SHALL be ignored.

Configuration
REQ-034 Macro RF_WBQ_FWD_EN SHALL gate lookup logic.
REQ-035 With RF_WBQ_FWD_EN defined, REQ-028..REQ-030 apply.
REQ-036 Without it, lk_hit and lk_data SHALL be tied to 0 and no comparators are synthesized; ports remain present.

Verification
REQ-037 Reset then push (5,0xA5) with wr_stall=0 -> next cycle wr_en=1, wr_addr=5, wr_data=0xA5; following cycle count=0, wr_en=0.
REQ-038 wr_stall=1, push 4 entries (1..4) -> count=4, in_ready=0; 5th push not accepted; release stall -> writes 1,2,3,4 in order on consecutive cycles.
REQ-039 count=3, simultaneous push and pop for 10 cycles -> count stays 3, pointers wrap, output order matches input order.
REQ-040 Push (0,0xFF) -> in_ready=1, count stays 0, wr_en stays 0.
REQ-041 FWD_EN, stall=1, push (7,0x11) then (7,0x22), lk_addr=7 -> lk_hit=1, lk_data=0x22; lk_addr=3 -> lk_hit=0, lk_data=0; without macro -> lk_hit=0 always.
REQ-042 count=3, assert rst for one cycle with in_valid=1 -> count=0, wr_en=0, in_ready=1; no stale entry written after reset.
